// File: rtl/cpu_pkg.sv
// Shared lab-CPU definitions: opcode/funct constants, ALU control encoding and
// instruction field slices used by the decode stage.
package cpu_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_ctr_e;

   function automatic logic [5:0] ir_op(input logic [31:0] ir);
      return ir[31:26];
   endfunction

   function automatic logic [4:0] ir_rs(input logic [31:0] ir);
      return ir[25:21];
   endfunction

   function automatic logic [4:0] ir_rt(input logic [31:0] ir);
      return ir[20:16];
   endfunction

   function automatic logic [4:0] ir_rd(input logic [31:0] ir);
      return ir[15:11];
   endfunction

   function automatic logic [15:0] ir_imm(input logic [31:0] ir);
      return ir[15:0];
   endfunction

   function automatic logic [5:0] ir_funct(input logic [31:0] ir);
      return ir[5:0];
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/WB-facing inputs and D/X-facing outputs of the decode stage.
interface decode_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic [31:0]           FD_IR;
   logic                  wb_en;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0]     wb_data;
   logic [DATA_W-1:0]     A;
   logic [DATA_W-1:0]     B;
   logic [DATA_W-1:0]     DX_SD;
   logic [REG_ADDR_W-1:0] DX_RD;
   logic [2:0]            ALUctr;
   logic                  DX_MemRead;
   logic                  DX_MemWrite;
   logic                  stall;

   modport master (
      output FD_IR, wb_en, wb_rd, wb_data,
      input  A, B, DX_SD, DX_RD, ALUctr, DX_MemRead, DX_MemWrite, stall
   );

   modport slave (
      input  FD_IR, wb_en, wb_rd, wb_data,
      output A, B, DX_SD, DX_RD, ALUctr, DX_MemRead, DX_MemWrite, stall
   );
endinterface

// File: rtl/reg_file.sv
// 2-read/1-write register file, r0 hardwired to zero.
// WB_BYPASS_EN: a same-cycle WB write is forwarded to a matching read port.
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0]     rdata_a,
   output logic [DATA_W-1:0]     rdata_b
);
   localparam int DEPTH = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;

   assign wr_ok = we && (waddr != {REG_ADDR_W{1'b0}});

   // Register array with asynchronous clear; writes to r0 are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      rdata_a = {DATA_W{1'b0}};
      rdata_b = {DATA_W{1'b0}};
      if (raddr_a == {REG_ADDR_W{1'b0}}) begin
         rdata_a = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (wr_ok && (waddr == raddr_a)) begin
         rdata_a = wdata;
`endif
      end else begin
         rdata_a = mem[raddr_a];
      end
      if (raddr_b == {REG_ADDR_W{1'b0}}) begin
         rdata_b = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (wr_ok && (waddr == raddr_b)) begin
         rdata_b = wdata;
`endif
      end else begin
         rdata_b = mem[raddr_b];
      end
   end
endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, register-file read, load-use stall and D/X pipeline register.
// Optional WB_BYPASS_EN macro enables write-then-read forwarding in reg_file.
module decode_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave bus
);
   logic [31:0]           ir;
   logic [5:0]            op;
   logic [5:0]            funct;
   logic [4:0]            rs;
   logic [4:0]            rt;
   logic [4:0]            rd;
   logic [15:0]           imm;
   logic                  shamt_unused;
   logic [DATA_W-1:0]     rs_data;
   logic [DATA_W-1:0]     rt_data;
   logic [DATA_W-1:0]     imm_sext;

   logic                  legal;
   logic                  is_rtype;
   logic                  is_lw;
   logic                  is_sw;
   alu_ctr_e              alu_n;
   logic                  hazard;

   logic [DATA_W-1:0]     a_n, b_n, sd_n;
   logic [REG_ADDR_W-1:0] rd_n;
   logic                  mr_n, mw_n;

   logic [DATA_W-1:0]     a_q, b_q, sd_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [2:0]            alu_q;
   logic                  mr_q, mw_q;

   assign ir           = bus.FD_IR;
   assign op           = ir_op(ir);
   assign funct        = ir_funct(ir);
   assign rs           = ir_rs(ir);
   assign rt           = ir_rt(ir);
   assign rd           = ir_rd(ir);
   assign imm          = ir_imm(ir);
   assign shamt_unused = ^ir[10:6];
   assign imm_sext     = {{(DATA_W-16){imm[15]}}, imm};

   reg_file #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .we      (bus.wb_en),
      .waddr   (bus.wb_rd),
      .wdata   (bus.wb_data),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_data),
      .rdata_b (rt_data)
   );

   // Instruction classification; unknown op/funct (including all-zero) is illegal.
   always_comb begin
      legal    = 1'b0;
      is_rtype = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      alu_n    = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            legal    = 1'b1;
            is_rtype = 1'b1;
            case (funct)
               FN_ADD:  alu_n = ALU_ADD;
               FN_SUB:  alu_n = ALU_SUB;
               FN_AND:  alu_n = ALU_AND;
               FN_OR:   alu_n = ALU_OR;
               FN_SLT:  alu_n = ALU_SLT;
               default: begin
                  legal    = 1'b0;
                  is_rtype = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            legal = 1'b1;
            is_lw = 1'b1;
         end
         OP_SW: begin
            legal = 1'b1;
            is_sw = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Load-use: rt only matters when it is actually read as an operand (R-type, sw store data).
   assign hazard = !rst && mr_q && legal && (rd_q != {REG_ADDR_W{1'b0}}) &&
                   ((rd_q == rs) || ((rd_q == rt) && (is_rtype || is_sw)));

   // Next D/X contents; stalls and illegal instructions insert a bubble.
   always_comb begin
      a_n  = {DATA_W{1'b0}};
      b_n  = {DATA_W{1'b0}};
      sd_n = {DATA_W{1'b0}};
      rd_n = {REG_ADDR_W{1'b0}};
      mr_n = 1'b0;
      mw_n = 1'b0;
      if (legal && !hazard) begin
         a_n = rs_data;
         if (is_rtype) begin
            b_n  = rt_data;
            rd_n = rd;
         end else if (is_lw) begin
            b_n  = imm_sext;
            rd_n = rt;
            mr_n = 1'b1;
         end else begin
            b_n  = imm_sext;
            sd_n = rt_data;
            mw_n = 1'b1;
         end
      end else begin
         a_n = {DATA_W{1'b0}};
      end
   end

   // D/X pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= {DATA_W{1'b0}};
         b_q   <= {DATA_W{1'b0}};
         sd_q  <= {DATA_W{1'b0}};
         rd_q  <= {REG_ADDR_W{1'b0}};
         alu_q <= 3'd0;
         mr_q  <= 1'b0;
         mw_q  <= 1'b0;
      end else begin
         a_q   <= a_n;
         b_q   <= b_n;
         sd_q  <= sd_n;
         rd_q  <= rd_n;
         alu_q <= (legal && !hazard) ? alu_n : ALU_ADD;
         mr_q  <= mr_n;
         mw_q  <= mw_n;
      end
   end

   assign bus.A           = a_q;
   assign bus.B           = b_q;
   assign bus.DX_SD       = sd_q;
   assign bus.DX_RD       = rd_q;
   assign bus.ALUctr      = alu_q;
   assign bus.DX_MemRead  = mr_q;
   assign bus.DX_MemWrite = mw_q;
   assign bus.stall       = hazard;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, sign-extension, r0, load-use stall,
// WB read-during-write (both WB_BYPASS_EN builds), reset mid-stall, illegal ops.
module tb_decode_stage;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   decode_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_byp;
      rst         = 1'b1;
      bus.FD_IR   = 32'd0;
      bus.wb_en   = 1'b0;
      bus.wb_rd   = 5'd0;
      bus.wb_data = 32'd0;
      #12;
      check("rst_A", bus.A, 32'd0);
      check("rst_B", bus.B, 32'd0);
      check("rst_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      check("rst_MemRead", {31'd0, bus.DX_MemRead}, 32'd0);
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: r1=5, r2=3, then add r3,r1,r2
      bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
      step();
      bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
      step();
      bus.wb_en = 1'b0;
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd3, FN_ADD);
      step();
      check("add_A", bus.A, 32'd5);
      check("add_B", bus.B, 32'd3);
      check("add_ALUctr", {29'd0, bus.ALUctr}, 32'd0);
      check("add_DX_RD", {27'd0, bus.DX_RD}, 32'd3);
      check("add_MemRead", {31'd0, bus.DX_MemRead}, 32'd0);

      // Test 2: sub, slt, and, or
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd4, FN_SUB);
      step();
      check("sub_ALUctr", {29'd0, bus.ALUctr}, 32'd1);
      check("sub_DX_RD", {27'd0, bus.DX_RD}, 32'd4);
      bus.FD_IR = rtype(5'd2, 5'd1, 5'd5, FN_SLT);
      step();
      check("slt_ALUctr", {29'd0, bus.ALUctr}, 32'd4);
      check("slt_DX_RD", {27'd0, bus.DX_RD}, 32'd5);
      check("slt_A", bus.A, 32'd3);
      check("slt_B", bus.B, 32'd5);
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd9, FN_AND);
      step();
      check("and_ALUctr", {29'd0, bus.ALUctr}, 32'd2);
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd9, FN_OR);
      step();
      check("or_ALUctr", {29'd0, bus.ALUctr}, 32'd3);

      // Test 3: lw r6,-4(r1) then dependent add r7,r6,r2
      bus.FD_IR = itype(OP_LW, 5'd1, 5'd6, 16'hFFFC);
      step();
      check("lw_A", bus.A, 32'd5);
      check("lw_B", bus.B, 32'hFFFF_FFFC);
      check("lw_DX_RD", {27'd0, bus.DX_RD}, 32'd6);
      check("lw_MemRead", {31'd0, bus.DX_MemRead}, 32'd1);
      check("lw_rt_nostall", {31'd0, bus.stall}, 32'd0);
      bus.FD_IR = rtype(5'd6, 5'd2, 5'd7, FN_ADD);
      #1;
      check("lu_stall", {31'd0, bus.stall}, 32'd1);
      step();
      check("bub_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      check("bub_MemRead", {31'd0, bus.DX_MemRead}, 32'd0);
      check("bub_B", bus.B, 32'd0);
      check("bub_stall", {31'd0, bus.stall}, 32'd0);
      step();
      check("issue_DX_RD", {27'd0, bus.DX_RD}, 32'd7);
      check("issue_B", bus.B, 32'd3);
      check("issue_stall", {31'd0, bus.stall}, 32'd0);

      // sw r2,8(r1)
      bus.FD_IR = itype(OP_SW, 5'd1, 5'd2, 16'h0008);
      step();
      check("sw_A", bus.A, 32'd5);
      check("sw_B", bus.B, 32'd8);
      check("sw_SD", bus.DX_SD, 32'd3);
      check("sw_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      check("sw_MemWrite", {31'd0, bus.DX_MemWrite}, 32'd1);

      // Test 4: write to r0 ignored
      bus.FD_IR = 32'd0;
      bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h0000_DEAD;
      step();
      check("nop_MemWrite", {31'd0, bus.DX_MemWrite}, 32'd0);
      bus.wb_en = 1'b0;
      bus.FD_IR = rtype(5'd0, 5'd0, 5'd11, FN_ADD);
      step();
      check("r0_A", bus.A, 32'd0);
      check("r0_B", bus.B, 32'd0);
      check("r0_DX_RD", {27'd0, bus.DX_RD}, 32'd11);

      // Test 5: same-cycle WB r8 and read of r8
`ifdef WB_BYPASS_EN
      exp_byp = 32'h0000_1234;
`else
      exp_byp = 32'h0000_0000;
`endif
      bus.wb_en = 1'b1; bus.wb_rd = 5'd8; bus.wb_data = 32'h0000_1234;
      bus.FD_IR = rtype(5'd8, 5'd0, 5'd12, FN_ADD);
      step();
      check("rdw_A", bus.A, exp_byp);
      bus.wb_en = 1'b0;
      step();
      check("r8_A", bus.A, 32'h0000_1234);

      // Test 6: reset during stall
      bus.FD_IR = itype(OP_LW, 5'd1, 5'd6, 16'h0000);
      step();
      bus.FD_IR = rtype(5'd6, 5'd2, 5'd7, FN_ADD);
      #1;
      check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
      check("mid_rst_MemRead", {31'd0, bus.DX_MemRead}, 32'd0);
      check("mid_rst_A", bus.A, 32'd0);
      check("mid_rst_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd13, FN_ADD);
      step();
      check("post_rst_A", bus.A, 32'd0);
      check("post_rst_B", bus.B, 32'd0);
      check("post_rst_DX_RD", {27'd0, bus.DX_RD}, 32'd13);

      // Illegal op after a load targeting its rs/rt: bubble, no stall
      bus.FD_IR = itype(OP_LW, 5'd0, 5'd1, 16'h0010);
      step();
      check("lw2_B", bus.B, 32'h0000_0010);
      check("lw2_DX_RD", {27'd0, bus.DX_RD}, 32'd1);
      bus.FD_IR = itype(6'h3F, 5'd1, 5'd1, 16'h0000);
      #1;
      check("ill_stall", {31'd0, bus.stall}, 32'd0);
      step();
      check("ill_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      check("ill_MemRead", {31'd0, bus.DX_MemRead}, 32'd0);
      check("ill_B", bus.B, 32'd0);
      bus.FD_IR = rtype(5'd1, 5'd2, 5'd9, 6'h21);
      step();
      check("illfn_DX_RD", {27'd0, bus.DX_RD}, 32'd0);
      check("illfn_ALUctr", {29'd0, bus.ALUctr}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
